// File: rtl/mac_tile_nlane.sv
// Systolic-array MAC tile with up to LANES stationary signed weights loaded serially
// over lane 0 of the west bus; accumulates lane products onto the north partial sum.
module mac_tile_nlane #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int LANES   = 2,
    parameter int LW      = $clog2(LANES) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [bw*LANES-1:0]   in_w,
    output logic [bw*LANES-1:0]   out_e,
    input  logic [1:0]            inst_w,
    output logic [1:0]            inst_e,
    input  logic [psum_bw-1:0]    in_n,
    output logic [psum_bw-1:0]    out_s,
    input  logic [LW-1:0]         lanes_act,
    input  logic                  rearm,
    output logic                  load_done
);

    typedef enum logic {LOADING = 1'b0, LOADED = 1'b1} state_t;

    localparam logic [LW-1:0] LANES_L = LW'(LANES);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

    state_t                      state, state_nxt;
    logic [LW-1:0]               cnt, cnt_nxt, act_q, act_nxt;
    logic [LW-1:0]               lanes_clamp, beat_act, act_eff;
    logic                        load_ready, beat, last_beat;

    logic [bw*LANES-1:0]         a_q;
    logic signed [psum_bw-1:0]   c_q;
    logic [1:0]                  inst_q;
    logic signed [bw-1:0]        w_q  [LANES];
    logic signed [psum_bw-1:0]   term [LANES];
    logic signed [psum_bw-1:0]   sum;

    // Zero means one lane; anything above LANES saturates at LANES.
    function automatic logic [LW-1:0] clamp_lanes(input logic [LW-1:0] n);
        if (n == '0)
            return ONE_L;
        else if (n > LANES_L)
            return LANES_L;
        else
            return n;
    endfunction

    function automatic logic signed [psum_bw-1:0] sext_prod(input logic signed [2*bw:0] p);
        return psum_bw'(p);
    endfunction

    assign load_ready  = (state == LOADING);
    assign beat        = load_ready & inst_w[0] & ~rearm;
    assign lanes_clamp = clamp_lanes(lanes_act);
    // The first beat compares against the count being latched on that same edge.
    assign beat_act    = (cnt == '0) ? lanes_clamp : act_q;
    assign last_beat   = (cnt == beat_act - ONE_L);
    assign act_eff     = clamp_lanes(act_q);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        act_nxt   = act_q;
        if (rearm) begin
            state_nxt = LOADING;
            cnt_nxt   = '0;
        end else if (beat) begin
            if (cnt == '0)
                act_nxt = lanes_clamp;
            if (last_beat) begin
                state_nxt = LOADED;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + ONE_L;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOADING;
            cnt   <= '0;
            act_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            act_q <= act_nxt;
        end
    end

    // Input register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            c_q    <= '0;
            inst_q <= '0;
        end else begin
            if (inst_w != 2'b00)
                a_q <= in_w;
            c_q       <= in_n;
            inst_q[1] <= inst_w[1];
            inst_q[0] <= inst_w[0] & ~load_ready & ~rearm;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (reset)
                w_q[k] <= '0;
            else if (beat && cnt == LW'(k))
                w_q[k] <= in_w[bw-1:0];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [2*bw:0] prod;
        assign prod    = $signed({1'b0, a_q[bw*k +: bw]}) * w_q[k];
        assign term[k] = (LW'(k) < act_eff) ? sext_prod(prod) : '0;
    end

    always_comb begin
        sum = c_q;
        for (int k = 0; k < LANES; k++)
            sum = sum + term[k];
    end

    assign out_s     = sum;
    assign out_e     = a_q;
    assign inst_e    = inst_q;
    assign load_done = ~load_ready;

endmodule

// File: tb/tb_mac_tile_nlane.sv
// Directed bench for mac_tile_nlane with LANES=2, bw=4, psum_bw=16.
module tb_mac_tile_nlane;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_w;
    logic [7:0]  out_e;
    logic [1:0]  inst_w;
    logic [1:0]  inst_e;
    logic [15:0] in_n;
    logic [15:0] out_s;
    logic [1:0]  lanes_act;
    logic        rearm;
    logic        load_done;

    int checks = 0;
    int errors = 0;

    mac_tile_nlane #(.bw(4), .psum_bw(16), .LANES(2)) dut (
        .clk(clk), .reset(reset), .in_w(in_w), .out_e(out_e),
        .inst_w(inst_w), .inst_e(inst_e), .in_n(in_n), .out_s(out_s),
        .lanes_act(lanes_act), .rearm(rearm), .load_done(load_done)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic [7:0] w, input logic [1:0] inst, input logic [15:0] n,
                       input logic [1:0] la, input logic rr);
        in_w = w; inst_w = inst; in_n = n; lanes_act = la; rearm = rr;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_w = 8'($urandom); inst_w = 2'($urandom); in_n = 16'($urandom);
            lanes_act = 2'($urandom); rearm = 1'($urandom);
            @(posedge clk); #1;
            checks++; if (out_e !== 8'h00) begin errors++; $display("FAIL reset_out_e cyc %0d got %h exp 00", i, out_e); end
            checks++; if (inst_e !== 2'b00) begin errors++; $display("FAIL reset_inst_e cyc %0d got %b exp 00", i, inst_e); end
            checks++; if (out_s !== 16'h0000) begin errors++; $display("FAIL reset_out_s cyc %0d got %h exp 0000", i, out_s); end
            checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done cyc %0d got %b exp 0", i, load_done); end
        end
        reset = 1'b0;
        cyc(8'h00, 2'b00, 16'h0000, 2'd1, 1'b0);
        checks++; if (out_e !== 8'h00) begin errors++; $display("FAIL post_reset_out_e got %h exp 00", out_e); end
        checks++; if (inst_e !== 2'b00) begin errors++; $display("FAIL post_reset_inst_e got %b exp 00", inst_e); end
        checks++; if (out_s !== 16'h0000) begin errors++; $display("FAIL post_reset_out_s got %h exp 0000", out_s); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL post_reset_load_done got %b exp 0", load_done); end
    endtask

    task automatic test_one_lane;
        cyc(8'h0D, 2'b01, 16'd0, 2'd1, 1'b0);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL one_lane_load_done got %b exp 1", load_done); end
        cyc(8'h05, 2'b10, 16'd100, 2'd1, 1'b0);
        checks++; if (out_s !== 16'd85) begin errors++; $display("FAIL one_lane_out_s got %0d exp 85", out_s); end
        checks++; if (inst_e !== 2'b10) begin errors++; $display("FAIL one_lane_inst_e got %b exp 10", inst_e); end
    endtask

    task automatic test_two_lane;
        cyc(8'h00, 2'b00, 16'd0, 2'd2, 1'b1);
        cyc(8'h03, 2'b01, 16'd0, 2'd2, 1'b0);
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL two_lane_beat1_done got %b exp 0", load_done); end
        cyc(8'h0E, 2'b01, 16'd0, 2'd2, 1'b0);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL two_lane_beat2_done got %b exp 1", load_done); end
        cyc(8'h74, 2'b10, 16'd0, 2'd2, 1'b0);
        checks++; if (out_s !== 16'hFFFE) begin errors++; $display("FAIL two_lane_out_s got %h exp FFFE", out_s); end
    endtask

    task automatic test_forwarding;
        cyc(8'h00, 2'b00, 16'd0, 2'd2, 1'b1);
        cyc(8'h01, 2'b01, 16'd0, 2'd2, 1'b0);
        checks++; if (inst_e[0] !== 1'b0) begin errors++; $display("FAIL fwd_beat1_inst got %b exp 0", inst_e[0]); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL fwd_beat1_done got %b exp 0", load_done); end
        cyc(8'h02, 2'b01, 16'd0, 2'd2, 1'b0);
        checks++; if (inst_e[0] !== 1'b0) begin errors++; $display("FAIL fwd_beat2_inst got %b exp 0", inst_e[0]); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL fwd_beat2_done got %b exp 1", load_done); end
        cyc(8'h09, 2'b01, 16'd0, 2'd2, 1'b0);
        checks++; if (inst_e !== 2'b01) begin errors++; $display("FAIL fwd_beat3_inst got %b exp 01", inst_e); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL fwd_beat3_done got %b exp 1", load_done); end
    endtask

    task automatic test_rearm_beat;
        cyc(8'h05, 2'b01, 16'd0, 2'd2, 1'b1);
        checks++; if (inst_e[0] !== 1'b0) begin errors++; $display("FAIL rearm_inst got %b exp 0", inst_e[0]); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rearm_done got %b exp 0", load_done); end
        cyc(8'h0F, 2'b01, 16'd0, 2'd2, 1'b0);
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rearm_beat1_done got %b exp 0", load_done); end
        cyc(8'h03, 2'b01, 16'd0, 2'd2, 1'b0);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL rearm_beat2_done got %b exp 1", load_done); end
        checks++; if (inst_e[0] !== 1'b0) begin errors++; $display("FAIL rearm_beat2_inst got %b exp 0", inst_e[0]); end
        cyc(8'h21, 2'b10, 16'h0010, 2'd2, 1'b0);
        checks++; if (out_s !== 16'h0015) begin errors++; $display("FAIL rearm_exec_out_s got %h exp 0015", out_s); end
    endtask

    task automatic test_overflow;
        cyc(8'h00, 2'b00, 16'd0, 2'd0, 1'b1);
        cyc(8'h07, 2'b01, 16'd0, 2'd0, 1'b0);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL ovf_zero_lanes_done got %b exp 1", load_done); end
        cyc(8'hFF, 2'b10, 16'h7FFF, 2'd0, 1'b0);
        checks++; if (out_s !== 16'h8068) begin errors++; $display("FAIL ovf_out_s got %h exp 8068", out_s); end
    endtask

    task automatic test_reset_mid_load;
        cyc(8'h00, 2'b00, 16'd0, 2'd3, 1'b1);
        cyc(8'h02, 2'b01, 16'd0, 2'd3, 1'b0);
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL mid_beat1_done got %b exp 0", load_done); end
        reset = 1'b1;
        cyc(8'h00, 2'b00, 16'd0, 2'd3, 1'b0);
        reset = 1'b0;
        checks++; if (out_s !== 16'h0000) begin errors++; $display("FAIL mid_reset_out_s got %h exp 0000", out_s); end
        cyc(8'h01, 2'b01, 16'd0, 2'd3, 1'b0);
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL mid_fresh_beat1_done got %b exp 0", load_done); end
        cyc(8'h04, 2'b01, 16'd0, 2'd3, 1'b0);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL mid_fresh_beat2_done got %b exp 1", load_done); end
        cyc(8'h11, 2'b10, 16'd0, 2'd3, 1'b0);
        checks++; if (out_s !== 16'd5) begin errors++; $display("FAIL mid_exec_out_s got %h exp 0005", out_s); end
    endtask

    task automatic test_back_to_back;
        cyc(8'h23, 2'b10, 16'h000A, 2'd1, 1'b0);
        checks++; if (out_s !== 16'h0015) begin errors++; $display("FAIL b2b_1_out_s got %h exp 0015", out_s); end
        cyc(8'hF0, 2'b10, 16'hFFFF, 2'd1, 1'b0);
        checks++; if (out_s !== 16'h003B) begin errors++; $display("FAIL b2b_2_out_s got %h exp 003B", out_s); end
        checks++; if (out_e !== 8'hF0) begin errors++; $display("FAIL b2b_2_out_e got %h exp F0", out_e); end
        cyc(8'hAA, 2'b00, 16'h0000, 2'd1, 1'b0);
        checks++; if (out_s !== 16'h003C) begin errors++; $display("FAIL b2b_hold_out_s got %h exp 003C", out_s); end
        checks++; if (out_e !== 8'hF0) begin errors++; $display("FAIL b2b_hold_out_e got %h exp F0", out_e); end
        checks++; if (inst_e !== 2'b00) begin errors++; $display("FAIL b2b_hold_inst_e got %b exp 00", inst_e); end
    endtask

    initial begin
        reset = 1'b1; in_w = '0; inst_w = '0; in_n = '0; lanes_act = '0; rearm = 1'b0;
        test_reset();
        test_one_lane();
        test_two_lane();
        test_forwarding();
        test_rearm_beat();
        test_overflow();
        test_reset_mid_load();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_tile_nlane.md
Name: mac_tile_nlane

Overview:
- Parametrised successor to the two-weight SIMD MAC tile: one systolic-array processing element holding up to LANES stationary weights.
- Loads the weights serially over the west activation bus, then runs one multiply-accumulate per lane each cycle.
- Adds the lane products to the north partial sum, passes activations and instructions east, and drives the result south.
- Adds a run-time active-lane count and a weight re-arm, so a tile can be reloaded without a global reset.

Parameters:
- bw, 4, bit width of one activation lane and one weight
- psum_bw, 16, partial-sum width
- LANES, 2, number of weight/activation lanes; legal values 1, 2, 4
- LW, $clog2(LANES)+1, width of lanes_act (derived, not overridden)

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- in_w  input  bw*LANES  packed activations, lane k at [bw*k +: bw]; lane 0 also carries weights during load
- out_e  output  bw*LANES  registered activations forwarded east
- inst_w  input  2  [1] execute, [0] kernel load
- inst_e  output  2  registered instruction forwarded east
- in_n  input  psum_bw  partial sum from north
- out_s  output  psum_bw  partial sum to south
- lanes_act  input  LW  active lane count; 0 is treated as 1, values above LANES are clamped to LANES
- rearm  input  1  pulse: re-enable weight loading
- load_done  output  1  high when all active weights are captured

Behaviour:
- Reset: a_q, c_q, all w_q[k], inst_q, the lane counter and the latched lane count clear to 0; load_ready=1.
  - Outputs after reset: out_e=0, inst_e=00, out_s=0, load_done=0.
- Registers:
  - a_q is captured from in_w whenever inst_w!=00, otherwise held.
  - c_q<=in_n every cycle.
  - inst_q[1]<=inst_w[1] every cycle.
- Load FSM, two states: LOADING (load_ready=1) and LOADED (load_ready=0).
  - In LOADING, a cycle with inst_w[0]=1 is a load beat: w_q[cnt]<=in_w[bw-1:0].
  - The first beat (cnt=0) latches lanes_act into act_q. Later changes to lanes_act are ignored until the next load sequence.
  - If cnt==act_q-1 after a beat: go to LOADED and set cnt=0. Otherwise cnt increments.
  - Weights of inactive lanes keep their old values but are masked in the arithmetic.
- inst_q[0]<=inst_w[0] only while the pre-edge load_ready is 0. A tile therefore consumes exactly act_q load beats and forwards all later beats east.
- load_done = ~load_ready.
- rearm: synchronous.
  - Sets load_ready=1 and cnt=0; weights are held until overwritten.
  - rearm has priority over a simultaneous load beat; that beat is not captured and is not forwarded.
  - After rearm, inst_q[0] gating uses the new state from the next cycle on.
- Arithmetic, combinational from registers:
  - out_s = c_q + sum over k<act_q of sext(a_q[k]*w_q[k]).
  - a lanes are unsigned; weights are signed two's complement.
  - Each product is 2*bw+1 bits signed, sign-extended to psum_bw. The sum wraps modulo 2^psum_bw with no saturation.
  - act_q=0 (before the first load) is treated as 1.
- Latency: in_n and in_w presented before edge t appear in out_s and out_e after edge t (one register stage). inst_e lags inst_w by one cycle.
- Reset mid-load: counter, act_q and weights are cleared; loading restarts at lane 0.
- Execute during LOADING: permitted. The MAC uses the current weight contents.
- A simultaneous load and execute beat (inst_w=11) captures the weight and updates a_q.
- Target implementation: generate loops over LANES, 150-250 lines.

Test Plan:
- Reset with inputs toggling -> out_e=0, inst_e=00, out_s=0, load_done=0 for the whole reset and on the first cycle after it.
- LANES=2, lanes_act=1: load beat in_w=8'h0D (w0=-3), then execute in_w=8'h05, in_n=100 -> out_s=85 one cycle after the execute edge; load_done=1 after the load beat.
- LANES=2, lanes_act=2: load beats in_w[3:0]=3 then 4'hE (-2); execute in_w=8'h74, in_n=0 -> out_s=16'hFFFE (12-14).
- Forwarding: three consecutive load beats with lanes_act=2 -> inst_e[0] is 0 after beats 1 and 2, 1 only after beat 3; load_done rises after beat 2.
- rearm pulse in the same cycle as a load beat -> beat ignored, inst_e[0]=0; the next two beats overwrite w0 and w1; the following execute uses the new weights.
- Overflow: w0=7, a0=15, in_n=16'h7FFF -> out_s=16'h8068 (wrap); reset after one of two load beats -> cnt=0 and a fresh two-beat load is required.
